// File: rtl/rom_load_sequencer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rom_load_pkg
// Description : Shared constants for the ROM download sequencer: FSM state
//               codes, ioctl download indices and the ROM region map.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package rom_load_pkg;

   // Size of the region table below; NUM_REGIONS must not exceed it.
   localparam int PKG_NUM_REGIONS = 4;

   // ioctl download indices handled by the sequencer
   localparam logic [7:0] IDX_ROM   = 8'd0;
   localparam logic [7:0] IDX_TITLE = 8'd1;
   localparam logic [7:0] IDX_DIP   = 8'd254;

   // Sequencer FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;

   // Region r covers byte addresses [REGION_BASE[r], REGION_END[r])
   localparam logic [31:0] REGION_BASE [PKG_NUM_REGIONS] =
      '{32'h0000_0000, 32'h0000_8000, 32'h0000_A000, 32'h0000_E000};
   localparam logic [31:0] REGION_END  [PKG_NUM_REGIONS] =
      '{32'h0000_8000, 32'h0000_A000, 32'h0000_E000, 32'h0001_0000};

endpackage
`default_nettype wire

// File: rtl/rom_load_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rom_load_sequencer_if
// Description : Byte-write bus from the download sequencer (master) to the
//               core ROM regions (slave). A byte is transferred on every
//               cycle where rom_we and rom_ack are both high.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface rom_load_sequencer_if #(
   parameter int RADDR_W = 16
) ();
   logic               rom_we;
   logic [2:0]         rom_sel;
   logic [RADDR_W-1:0] rom_addr;
   logic [7:0]         rom_data;
   logic               rom_ack;

   modport master (output rom_we, output rom_sel, output rom_addr,
                   output rom_data, input rom_ack);
   modport slave  (input rom_we, input rom_sel, input rom_addr,
                   input rom_data, output rom_ack);
endinterface
`default_nettype wire

// File: rtl/rom_load_sequencer_decode.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rom_region_decode
// Description : Combinational byte-address decode into ROM region number and
//               region-relative address. The lowest region whose end bound
//               exceeds the address wins; no match clears hit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module rom_region_decode
   import rom_load_pkg::*;
#(
   parameter int ADDR_W      = 27,
   parameter int RADDR_W     = 16,
   parameter int NUM_REGIONS = 4
) (
   input  logic [ADDR_W-1:0]  byte_addr,
   output logic               hit,
   output logic [2:0]         sel,
   output logic [RADDR_W-1:0] rel_addr
);

   logic [31:0] addr32;
   assign addr32 = 32'(byte_addr);

   // Scan from the top region down so the lowest matching region is kept
   always_comb begin
      hit      = 1'b0;
      sel      = '0;
      rel_addr = '0;
      for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
         if (addr32 < REGION_END[r]) begin
            hit      = 1'b1;
            sel      = 3'(r);
            rel_addr = RADDR_W'(addr32 - REGION_BASE[r]);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rom_load_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rom_load_sequencer
// Description : Turns the hps_io ioctl download stream into byte writes to the
//               core ROM regions, stalling the HPS with ioctl_wait until each
//               byte is accepted. Also captures DIP-switch and title bytes and
//               flags completion of the core ROM download.
//               Optional macro LOADER_CHECKSUM_EN adds the rom_sum output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module rom_load_sequencer
   import rom_load_pkg::*;
#(
   parameter int ADDR_W      = 27,
   parameter int RADDR_W     = 16,
   parameter int NUM_REGIONS = 4
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [15:0]       ioctl_dout,
   output logic              ioctl_wait,
   rom_load_sequencer_if.master rom,
   output logic [63:0]       dsw,
   output logic [7:0]        title,
   output logic              rom_loaded,
`ifdef LOADER_CHECKSUM_EN
   output logic [15:0]       rom_sum,
`endif
   output logic              drop_err
);

   logic [1:0]         state;
   logic [ADDR_W-1:0]  lat_addr;
   logic [7:0]         lat_hi;
   logic [7:0]         idx_q;
   logic               dl_q;
   logic               load_pend;

   logic               dl_rise;
   logic               dl_fall;
   logic               rom_start;
   logic               rom_strobe;
   logic               byte_done;

   logic [ADDR_W-1:0]  dec_addr;
   logic               dec_hit;
   logic [2:0]         dec_sel;
   logic [RADDR_W-1:0] dec_rel;

   assign dl_rise    = ioctl_download & ~dl_q;
   assign dl_fall    = ~ioctl_download & dl_q;
   assign rom_start  = dl_rise & (ioctl_index == IDX_ROM);
   assign rom_strobe = ioctl_wr & ioctl_download & (ioctl_index == IDX_ROM)
                       & (state == ST_IDLE);
   // A byte is finished when accepted, or immediately when it was skipped
   assign byte_done  = ~rom.rom_we | rom.rom_ack;

   // The single decoder looks at the incoming low byte while idle and at the
   // high byte (addr+1) while the low byte is in flight.
   assign dec_addr = (state == ST_IDLE) ? ioctl_addr : (lat_addr + ADDR_W'(1));

   rom_region_decode #(
      .ADDR_W      (ADDR_W),
      .RADDR_W     (RADDR_W),
      .NUM_REGIONS (NUM_REGIONS)
   ) u_decode (
      .byte_addr (dec_addr),
      .hit       (dec_hit),
      .sel       (dec_sel),
      .rel_addr  (dec_rel)
   );

   // Word FSM: latch the word, then present low and high bytes in turn
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state        <= ST_IDLE;
         lat_addr     <= '0;
         lat_hi       <= '0;
         ioctl_wait   <= 1'b0;
         rom.rom_we   <= 1'b0;
         rom.rom_sel  <= '0;
         rom.rom_addr <= '0;
         rom.rom_data <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rom_strobe) begin
                  lat_addr     <= ioctl_addr;
                  lat_hi       <= ioctl_dout[15:8];
                  ioctl_wait   <= 1'b1;
                  rom.rom_we   <= dec_hit;
                  rom.rom_sel  <= dec_sel;
                  rom.rom_addr <= dec_rel;
                  rom.rom_data <= ioctl_dout[7:0];
                  state        <= ST_LO;
               end
            end
            ST_LO: begin
               if (byte_done) begin
                  rom.rom_we   <= dec_hit;
                  rom.rom_sel  <= dec_sel;
                  rom.rom_addr <= dec_rel;
                  rom.rom_data <= lat_hi;
                  state        <= ST_HI;
               end
            end
            ST_HI: begin
               if (byte_done) begin
                  rom.rom_we <= 1'b0;
                  ioctl_wait <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Sticky error: cleared by a new ROM download, set by a busy strobe or a
   // byte that falls outside every region
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         drop_err <= 1'b0;
      end else begin
         if (rom_start)
            drop_err <= 1'b0;
         if ((ioctl_wr && state != ST_IDLE) ||
             (rom_strobe && !dec_hit) ||
             (state == ST_LO && byte_done && !dec_hit))
            drop_err <= 1'b1;
      end
   end

   // DIP-switch and title bytes are captured directly in the strobe cycle
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         dsw   <= '0;
         title <= '0;
      end else if (ioctl_wr && ioctl_download && state == ST_IDLE) begin
         if (ioctl_index == IDX_DIP && ioctl_addr[24:3] == '0)
            dsw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout[7:0];
         if (ioctl_index == IDX_TITLE)
            title <= ioctl_dout[7:0];
      end
   end

   // Download tracking: rom_loaded rises when an index-0 download ends and
   // the last word has drained out of the FSM
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         dl_q       <= 1'b0;
         idx_q      <= '0;
         load_pend  <= 1'b0;
         rom_loaded <= 1'b0;
      end else begin
         dl_q <= ioctl_download;
         if (dl_rise) begin
            idx_q     <= ioctl_index;
            load_pend <= 1'b0;
            if (ioctl_index == IDX_ROM)
               rom_loaded <= 1'b0;
         end else if (dl_fall && idx_q == IDX_ROM) begin
            if (state == ST_IDLE)
               rom_loaded <= 1'b1;
            else
               load_pend  <= 1'b1;
         end else if (load_pend && state == ST_IDLE) begin
            rom_loaded <= 1'b1;
            load_pend  <= 1'b0;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Running 16-bit sum of every byte accepted by the target
   always_ff @(posedge clk_sys) begin
      if (reset || rom_start)
         rom_sum <= '0;
      else if (rom.rom_we && rom.rom_ack)
         rom_sum <= rom_sum + 16'(rom.rom_data);
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_load_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_rom_load_sequencer
// Description : Directed self-checking bench for rom_load_sequencer.
//               Exercises the LOADER_CHECKSUM_EN output when that macro is set.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_rom_load_sequencer;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [26:0] ioctl_addr;
   logic [15:0] ioctl_dout;
   logic        ioctl_wait;
   logic [63:0] dsw;
   logic [7:0]  title;
   logic        rom_loaded;
   logic        drop_err;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0] rom_sum;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk_sys = ~clk_sys;

   rom_load_sequencer_if #(.RADDR_W(16)) rom_bus ();

   rom_load_sequencer #(
      .ADDR_W      (27),
      .RADDR_W     (16),
      .NUM_REGIONS (4)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .rom            (rom_bus),
      .dsw            (dsw),
      .title          (title),
      .rom_loaded     (rom_loaded),
`ifdef LOADER_CHECKSUM_EN
      .rom_sum        (rom_sum),
`endif
      .drop_err       (drop_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bus packed as {we, sel, addr, data}
   task automatic check_bus(input string tag, input logic we, input logic [2:0] sel,
                            input logic [15:0] addr, input logic [7:0] data);
      check(tag, {rom_bus.rom_we, rom_bus.rom_sel, rom_bus.rom_addr, rom_bus.rom_data},
            {we, sel, addr, data});
   endtask

   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic strobe(input logic [26:0] addr, input logic [15:0] dout);
      ioctl_wr   = 1'b1;
      ioctl_addr = addr;
      ioctl_dout = dout;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
      ioctl_addr = '0; ioctl_dout = '0; rom_bus.rom_ack = 1'b1;
      repeat (3) tick();
      check_bus("reset_bus", 1'b0, 3'd0, 16'h0000, 8'h00);
      check("reset_misc", {ioctl_wait, rom_loaded, drop_err, title}, 11'h000);
      check("reset_dsw", dsw, 64'h0);
      reset = 1'b0;

      // DIP byte 3 and title byte, no stall
      ioctl_index = 8'd254; ioctl_download = 1'b1; tick();
      strobe(27'd3, 16'h00A5);
      check("dip_nowait", ioctl_wait, 1'b0);
      check("dip_dsw", dsw, 64'h0000_0000_A500_0000);
      tick();
      check("dip_nowait2", ioctl_wait, 1'b0);
      ioctl_download = 1'b0; tick();
      ioctl_index = 8'd1; ioctl_download = 1'b1; tick();
      strobe(27'd0, 16'h0001);
      check("title", title, 8'h01);
      ioctl_download = 1'b0; tick();
      check("title_not_loaded", rom_loaded, 1'b0);

      // ROM word with immediate ack
      ioctl_index = 8'd0; ioctl_download = 1'b1; tick();
      strobe(27'h10, 16'hBEEF);
      check_bus("w1_lo", 1'b1, 3'd0, 16'h0010, 8'hEF);
      check("w1_wait_lo", ioctl_wait, 1'b1);
      tick();
      check_bus("w1_hi", 1'b1, 3'd0, 16'h0011, 8'hBE);
      check("w1_wait_hi", ioctl_wait, 1'b1);
      tick();
      check("w1_done", {rom_bus.rom_we, ioctl_wait}, 2'b00);

      // Low byte held off by ack for 5 cycles
      rom_bus.rom_ack = 1'b0;
      strobe(27'h20, 16'h5678);
      check_bus("w2_lo0", 1'b1, 3'd0, 16'h0020, 8'h78);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_bus("w2_lo_hold", 1'b1, 3'd0, 16'h0020, 8'h78);
         check("w2_wait_hold", ioctl_wait, 1'b1);
      end
      rom_bus.rom_ack = 1'b1; tick();
      check_bus("w2_hi", 1'b1, 3'd0, 16'h0021, 8'h56);
      rom_bus.rom_ack = 1'b0; tick();
      check_bus("w2_hi_hold", 1'b1, 3'd0, 16'h0021, 8'h56);
      check("w2_wait_hi", ioctl_wait, 1'b1);
      rom_bus.rom_ack = 1'b1; tick();
      check("w2_done", {rom_bus.rom_we, ioctl_wait}, 2'b00);

      // Word straddling region 1/2, then word outside every region
      strobe(27'h9FFF, 16'h1234);
      check_bus("w3_lo", 1'b1, 3'd1, 16'h1FFF, 8'h34);
      tick();
      check_bus("w3_hi", 1'b1, 3'd2, 16'h0000, 8'h12);
      tick();
      check("w3_noerr", drop_err, 1'b0);
      strobe(27'h10000, 16'hCAFE);
      check("w4_lo_skip", {rom_bus.rom_we, ioctl_wait}, 2'b01);
      tick();
      check("w4_hi_skip", {rom_bus.rom_we, ioctl_wait}, 2'b01);
      tick();
      check("w4_done", {rom_bus.rom_we, ioctl_wait}, 2'b00);
      check("w4_drop_err", drop_err, 1'b1);

      // Download ends while idle
      ioctl_download = 1'b0; tick();
      check("loaded_idle", rom_loaded, 1'b1);
      ioctl_download = 1'b1; tick();
      check("restart_clear", {rom_loaded, drop_err}, 2'b00);

      // Download ends while HI is waiting for ack
      strobe(27'h30, 16'h4321);
      check_bus("w5_lo", 1'b1, 3'd0, 16'h0030, 8'h21);
      tick();
      check_bus("w5_hi", 1'b1, 3'd0, 16'h0031, 8'h43);
      rom_bus.rom_ack = 1'b0; ioctl_download = 1'b0; tick();
      check("w5_fall_busy", {rom_loaded, ioctl_wait}, 2'b01);
      tick();
      check("w5_still_busy", rom_loaded, 1'b0);
      rom_bus.rom_ack = 1'b1; tick();
      check("w5_idle", {rom_loaded, ioctl_wait}, 2'b00);
      tick();
      check("w5_loaded", rom_loaded, 1'b1);

      // Busy strobe sets drop_err; reset in LO aborts the word
      ioctl_download = 1'b1; tick();
      rom_bus.rom_ack = 1'b0;
      strobe(27'h50, 16'h1111);
      check_bus("w6_lo", 1'b1, 3'd0, 16'h0050, 8'h11);
      strobe(27'h52, 16'h2222);
      check_bus("w6_busy_hold", 1'b1, 3'd0, 16'h0050, 8'h11);
      check("w6_busy_drop", drop_err, 1'b1);
      reset = 1'b1; tick();
      check("w6_reset", {rom_bus.rom_we, ioctl_wait, rom_loaded, drop_err}, 4'b0000);
      reset = 1'b0; rom_bus.rom_ack = 1'b1; tick();
      check("w6_after_reset", {rom_bus.rom_we, ioctl_wait}, 2'b00);

`ifdef LOADER_CHECKSUM_EN
      strobe(27'h60, 16'h02FF);
      tick();
      tick();
      check("checksum", rom_sum, 16'h0101);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
